// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the multi-cycle multiply/divide sequencer and the ALU decoder.
// Holds the ALU long-op codes, the sequencer state encoding and the iteration counter width.
package muldiv_sequencer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ITER_W = $clog2(DATA_W);

    localparam logic [3:0] ALU_MULT  = 4'b1100;
    localparam logic [3:0] ALU_MULTU = 4'b1101;
    localparam logic [3:0] ALU_DIV   = 4'b1110;
    localparam logic [3:0] ALU_DIVU  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // Any code with the top two bits set is a long operation.
    function automatic logic is_muldiv(input logic [3:0] code);
        return code[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_step.sv
// One iteration of the unsigned shift-add multiplier or restoring divider.
// Pure combinational; the sequencer owns the accumulator and the counter.
module muldiv_sequencer_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        sum     = '0;
        trial   = '0;
        acc_out = acc_in;
        if (is_div) begin
            // acc = {remainder, remaining dividend bits}; bit WIDTH of trial is the borrow.
            trial = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]} - {1'b0, operand};
            if (!trial[WIDTH]) begin
                acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {acc_in[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            // acc = {partial product, remaining multiplier bits}, consumed LSB first.
            sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative mult/multu/div/divu sequencer owning the HI/LO registers.
// Operates on magnitudes for WIDTH cycles, then applies the sign fix-up in a single FIX cycle.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [ITER_W-1:0]  counter;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div;
    logic               is_signed;
    logic               neg_a;
    logic               neg_b;

    logic               accept;
    logic               in_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               flip;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign accept    = (state == IDLE) && start && is_muldiv(alu_control);
    assign in_signed = ~alu_control[0];
    assign a_mag     = (in_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign b_mag     = (in_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    muldiv_sequencer_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_in  (acc),
        .operand (operand),
        .acc_out (acc_step)
    );

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = CALC;
            CALC: begin
                if (flush)                                 state_next = IDLE;
                else if (counter == ITER_W'(WIDTH - 1))    state_next = FIX;
            end
            FIX:  state_next = flush ? IDLE : DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Sign fix-up; divide-by-zero bypasses it and returns the raw dividend.
    always_comb begin
        flip   = is_signed && (neg_a ^ neg_b);
        prod   = flip ? -acc : acc;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (operand == '0) begin
                fix_hi = a_raw;
                fix_lo = '1;
            end else begin
                fix_lo = flip ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                fix_hi = (is_signed && neg_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    // NOTE: the datapath is small, so every register is reset; nothing here is memory-like.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter   <= '0;
            acc       <= '0;
            operand   <= '0;
            a_raw     <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (accept) begin
                        is_div    <= alu_control[1];
                        is_signed <= in_signed;
                        neg_a     <= op_a[WIDTH-1];
                        neg_b     <= op_b[WIDTH-1];
                        a_raw     <= op_a;
                        counter   <= '0;
                        operand   <= alu_control[1] ? b_mag : a_mag;
                        acc       <= alu_control[1] ? {{WIDTH{1'b0}}, a_mag}
                                                    : {{WIDTH{1'b0}}, b_mag};
                    end
                end
                CALC: begin
                    acc     <= acc_step;
                    counter <= counter + ITER_W'(1);
                end
                FIX: begin
                    if (!flush) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: vector table through a result scoreboard, plus flush/reset/ignore sequences.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   alu_control;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         flush;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*W-1:0] sb[$];

    typedef struct {
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issues one operation and follows it to completion. Samples 1 time unit after each edge;
    // sample j reflects the state after edge E(j), so done is captured by the pipeline at E(j+1).
    task automatic run_op(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input int inject_at, input bit mthi_same_edge);
        int busy_cyc = 0;
        int done_cyc = 0;
        int lat      = -1;
        @(negedge clk);
        start = 1'b1; alu_control = ctrl; op_a = a; op_b = b;
        if (mthi_same_edge) begin hi_we = 1'b1; wdata = 32'hDEADBEEF; end
        sb.push_back({exp_hi, exp_lo});
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        if (mthi_same_edge) check("mthi_with_start", {32'h0, hi}, {32'h0, 32'hDEADBEEF});
        for (int j = 0; j < 60; j++) begin
            if (j == inject_at) begin
                start = 1'b1; alu_control = ALU_DIVU; op_a = 32'd100; op_b = 32'd0;
            end else begin
                start = 1'b0;
            end
            if (!busy) break;
            busy_cyc++;
            if (done) begin
                done_cyc++;
                lat = j + 1;
                if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
                else                check("result", {hi, lo}, sb.pop_front());
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done_seen", 64'(done_cyc), 64'd1);
        check("busy_cycles", 64'(busy_cyc), 64'd34);
        check("done_latency", 64'(lat), 64'd34);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; alu_control = 4'b0000; op_a = '0; op_b = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

        // {ctrl, a, b, exp_hi, exp_lo}
        vecs.push_back('{ALU_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1});
        vecs.push_back('{ALU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE});
        vecs.push_back('{ALU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
        vecs.push_back('{ALU_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF});
        vecs.push_back('{ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
        vecs.push_back('{ALU_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001});
        vecs.push_back('{ALU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
        vecs.push_back('{ALU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
        vecs.push_back('{ALU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14});
        vecs.push_back('{ALU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD});
        vecs.push_back('{ALU_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF});

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {30'd0, busy, done, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Non-muldiv code with start must not launch anything.
        @(negedge clk); start = 1'b1; alu_control = 4'b0010; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk); #1; start = 1'b0;
        check("ignore_bad_code", {63'd0, busy}, 64'd0);

        foreach (vecs[i])
            run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, -1, 1'b0);

        // mthi in the same cycle as an accepted start lands, then is overwritten at FIX.
        run_op(ALU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, -1, 1'b1);

        // A divu start during CALC is ignored; exactly one result appears.
        run_op(ALU_MULT, 32'd9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFEE, 5, 1'b0);
        begin
            int extra = 0;
            for (int j = 0; j < 40; j++) begin
                @(posedge clk); #1;
                if (done || busy) extra++;
            end
            check("no_second_op", 64'(extra), 64'd0);
        end

        // Preload HI/LO, start, attempt mthi while busy, then flush 10 cycles after the start edge.
        @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5A5A5A5A;
        @(negedge clk); lo_we = 1'b0; start = 1'b1; alu_control = ALU_MULT; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk); #1; start = 1'b0;
        begin
            int dones = 0;
            for (int j = 0; j < 10; j++) begin
                hi_we = (j == 3); wdata = 32'h0;
                if (done) dones++;
                @(posedge clk); #1;
            end
            hi_we = 1'b0;
            check("busy_before_flush", {63'd0, busy}, 64'd1);
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            check("flush_busy", {63'd0, busy}, 64'd0);
            for (int j = 0; j < 40; j++) begin
                if (done) dones++;
                @(posedge clk); #1;
            end
            check("flush_no_done", 64'(dones), 64'd0);
            check("flush_hilo", {hi, lo}, {32'hA5A5A5A5, 32'h5A5A5A5A});
        end

        // Flush while idle does nothing.
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle", {31'd0, busy, hi}, {32'd0, 32'hA5A5A5A5});

        // Synchronous reset in the middle of CALC.
        @(negedge clk); start = 1'b1; alu_control = ALU_DIVU; op_a = 32'd50; op_b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_calc", {31'd0, busy, done, hi, lo[W-2:0]}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;
        sb.delete();

        // Still functional after reset.
        run_op(ALU_DIVU, 32'd50, 32'd3, 32'd2, 32'd16, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
